// File: rtl/instr_fetch_if.sv
// Instruction stream from instr_fetch to instr_decoder (valid/ready handshake).
interface instr_fetch_if #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_W      = 6
);
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_W-1:0]      out_pc;
  logic                   out_valid;
  logic                   out_ready;

  modport master (output out_instr, output out_pc, output out_valid, input out_ready);
  modport slave  (input out_instr, input out_pc, input out_valid, output out_ready);
endinterface

// File: rtl/instr_fetch.sv
// Per-sample instruction sequencer: streams RAM words 0..len-1 to the decoder
// on each sample tick through a 2-entry skid buffer; accepts program writes when idle.
module instr_fetch #(
  parameter int unsigned N_INSTRS    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  localparam int unsigned ADDR_W     = $clog2(N_INSTRS),
  localparam int unsigned LEN_W      = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [LEN_W-1:0]       n_instr,
  input  logic                   instr_wr_en,
  input  logic [ADDR_W-1:0]      instr_wr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_wr_data,
  instr_fetch_if.master          dec,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   wr_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  logic [INSTR_WIDTH-1:0] mem [N_INSTRS];

  state_t                 state, state_n;
  logic [LEN_W-1:0]       len, len_n, n_clamped;
  logic [ADDR_W-1:0]      pc, pc_n;
  logic                   busy_n, done_n, overrun_n, wr_err_n;
  logic                   issue, ram_we, pop, drained;
  logic [1:0]             held;
  logic [INSTR_WIDTH-1:0] rd_word;

  logic                   skid_valid;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_W-1:0]      skid_pc;

  assign pop       = dec.out_valid & dec.out_ready;
  assign held      = 2'(dec.out_valid) + 2'(skid_valid);
  assign n_clamped = (n_instr > LEN_W'(N_INSTRS)) ? LEN_W'(N_INSTRS) : n_instr;
  // Both entries empty once this cycle's handshake (if any) completes.
  assign drained   = (held == 2'd0) || ((held == 2'd1) && pop);
  assign rd_word   = mem[pc];

  // Next-state, read issue and flag pulses.
  always_comb begin
    state_n   = state;
    len_n     = len;
    pc_n      = pc;
    busy_n    = busy;
    done_n    = 1'b0;
    overrun_n = 1'b0;
    wr_err_n  = 1'b0;
    issue     = 1'b0;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          if (n_clamped != '0) begin
            state_n = FETCH;
            len_n   = n_clamped;
            pc_n    = '0;
            busy_n  = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
        // A write racing a program start loses: busy begins on that edge.
        if (instr_wr_en) begin
          if (sample_tick && (n_clamped != '0)) wr_err_n = 1'b1;
          else                                  ram_we   = 1'b1;
        end
      end
      FETCH: begin
        overrun_n = sample_tick;
        wr_err_n  = instr_wr_en;
        if (held < 2'd2) begin
          issue = 1'b1;
          if (LEN_W'(pc) == (len - LEN_W'(1))) state_n = DRAIN;
          else                                 pc_n    = pc + ADDR_W'(1);
        end
      end
      DRAIN: begin
        overrun_n = sample_tick;
        wr_err_n  = instr_wr_en;
        if (drained) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      pc      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_n;
      len     <= len_n;
      pc      <= pc_n;
      busy    <= busy_n;
      done    <= done_n;
      overrun <= overrun_n;
      wr_err  <= wr_err_n;
    end
  end

  // Program RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[instr_wr_addr] <= instr_wr_data;
  end

  // Output register plus skid entry; the read result lands directly in a free slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec.out_valid <= 1'b0;
      dec.out_instr <= '0;
      dec.out_pc    <= '0;
      skid_valid    <= 1'b0;
      skid_instr    <= '0;
      skid_pc       <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        dec.out_instr <= skid_instr;
        dec.out_pc    <= skid_pc;
        skid_valid    <= 1'b0;
      end else if (issue) begin
        dec.out_instr <= rd_word;
        dec.out_pc    <= pc;
      end else begin
        dec.out_valid <= 1'b0;
      end
    end else if (issue) begin
      if (dec.out_valid) begin
        skid_instr <= rd_word;
        skid_pc    <= pc;
        skid_valid <= 1'b1;
      end else begin
        dec.out_instr <= rd_word;
        dec.out_pc    <= pc;
        dec.out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of program runs, hand-written
// stall/overrun/reset sequences and randomized programs against a RAM-shadow model.
module tb_instr_fetch;

  localparam int N    = 64;
  localparam int M_RDY   = 0;
  localparam int M_RND   = 1;
  localparam int M_STALL = 2;
  localparam int BOUND   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [6:0]  n_instr;
  logic        instr_wr_en;
  logic [5:0]  instr_wr_addr;
  logic [31:0] instr_wr_data;
  logic        busy, done, overrun, wr_err;

  instr_fetch_if #(.INSTR_WIDTH(32), .ADDR_W(6)) ifc ();

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .n_instr      (n_instr),
    .instr_wr_en  (instr_wr_en),
    .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data),
    .dec          (ifc),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .wr_err       (wr_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] ref_mem [N];

  typedef struct {
    int n;
    int mode;
    int inj;
    int exp_words;
    int exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      M_RND:   return 1'($urandom_range(0, 1));
      M_STALL: return !(c >= 2 && c <= 6);
      default: return 1'b1;
    endcase
  endfunction

  task automatic wr_word(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    instr_wr_en   = 1'b1;
    instr_wr_addr = 6'(a);
    instr_wr_data = d;
    ref_mem[a]    = d;
    @(posedge clk); #1;
    instr_wr_en   = 1'b0;
  endtask

  // Tick once, then watch the stream until the cycle after done. An injected
  // tick + write to address 2 at cycle inj must be flagged and otherwise ignored.
  task automatic run_prog(input int n, input int mode, input int inj,
                          output int words, output int done_cyc);
    int   len;
    int   next_idx;
    int   last_hs;
    int   dones;
    bit   prev_stall;
    bit   finished;
    logic exp_busy, exp_done;
    len        = (n > N) ? N : n;
    next_idx   = 0;
    last_hs    = -10;
    dones      = 0;
    prev_stall = 1'b0;
    finished   = 1'b0;
    words      = 0;
    done_cyc   = -1;
    for (int c = 0; c < BOUND; c++) begin
      @(posedge clk); #1;
      sample_tick   = (c == 0) || (inj > 0 && c == inj);
      n_instr       = 7'(n);
      instr_wr_en   = (inj > 0 && c == inj);
      instr_wr_addr = 6'd2;
      instr_wr_data = 32'hDEAD_BEEF;
      ifc.out_ready = ready_for(mode, c);
      @(negedge clk);
      exp_busy = (c >= 1) && (next_idx < len);
      exp_done = (len == 0 && c == 1) || (len > 0 && last_hs == c - 1 && next_idx == len);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("overrun", 32'(overrun), 32'(inj > 0 && c == inj + 1));
      check("wr_err", 32'(wr_err), 32'(inj > 0 && c == inj + 1));
      if (prev_stall) check("valid_held", 32'(ifc.out_valid), 32'd1);
      if (next_idx >= len) begin
        check("no_extra_word", 32'(ifc.out_valid), 32'd0);
      end else if (ifc.out_valid) begin
        check("out_instr", ifc.out_instr, ref_mem[next_idx]);
        check("out_pc", 32'(ifc.out_pc), 32'(next_idx));
      end
      if (ifc.out_valid && ifc.out_ready && next_idx < len) begin
        next_idx++;
        last_hs = c;
        words++;
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        finished = 1'b1;
        break;
      end
    end
    sample_tick   = 1'b0;
    instr_wr_en   = 1'b0;
    ifc.out_ready = 1'b1;
    check("finished_in_budget", 32'(finished), 32'd1);
    check("done_pulses", 32'(dones), 32'd1);
    check("word_count", 32'(words), 32'(len));
  endtask

  initial begin
    int words, dcyc, len;
    vecs[0] = '{4,   M_RDY,   0, 4,  6};
    vecs[1] = '{4,   M_STALL, 0, 4,  11};
    vecs[2] = '{8,   M_RDY,   3, 8,  10};
    vecs[3] = '{4,   M_RDY,   0, 4,  6};
    vecs[4] = '{0,   M_RDY,   0, 0,  1};
    vecs[5] = '{100, M_RDY,   0, 64, 66};
    vecs[6] = '{1,   M_RDY,   0, 1,  3};
    vecs[7] = '{13,  M_RND,   0, 13, -1};

    reset         = 1'b1;
    sample_tick   = 1'b0;
    n_instr       = '0;
    instr_wr_en   = 1'b0;
    instr_wr_addr = '0;
    instr_wr_data = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_instr", ifc.out_instr, 32'd0);
    check("rst_pc", 32'(ifc.out_pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({overrun, wr_err}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < N; i++)
      wr_word(i, (i < 4) ? 32'hA0 + 32'(i) : 32'(i * 3));

    // Table of program runs.
    for (int v = 0; v < 8; v++) begin
      run_prog(vecs[v].n, vecs[v].mode, vecs[v].inj, words, dcyc);
      check("vec_words", 32'(words), 32'(vecs[v].exp_words));
      if (vecs[v].exp_done >= 0) check("vec_done_cycle", 32'(dcyc), 32'(vecs[v].exp_done));
    end

    // Full 64-word program under random back-pressure.
    for (int i = 0; i < 4; i++) wr_word(i, 32'(i * 3));
    run_prog(64, M_RND, 0, words, dcyc);
    check("rand64_words", 32'(words), 32'd64);

    // Reset after two of eight words have been handed off.
    @(posedge clk); #1;
    sample_tick = 1'b1; n_instr = 7'd8; ifc.out_ready = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("pre_reset_pc", 32'(ifc.out_pc), 32'd2);
    check("pre_reset_valid", 32'(ifc.out_valid), 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pc", 32'(ifc.out_pc), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_idle_valid", 32'(ifc.out_valid), 32'd0);
    run_prog(8, M_RDY, 0, words, dcyc);
    check("restart_done_cycle", 32'(dcyc), 32'd10);

    // Randomized programs and RAM updates.
    for (int k = 0; k < 6; k++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int j = 0; j < nw; j++)
        wr_word(int'($urandom_range(0, N - 1)), $urandom);
      len = int'($urandom_range(0, 80));
      run_prog(len, ($urandom_range(0, 1) == 1) ? M_RND : M_RDY, 0, words, dcyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
